// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants, decoder state type and PS/2 set-1 to BBC matrix translation.
// The keypad/arrow split is selected by KBD_EXTENDED_KEYS_EN.
package kbd_pkg;

  localparam int KBD_NCOLS = 10;
  localparam int KBD_NROWS = 8;
  localparam int KBD_COLW  = 4;
  localparam int KBD_ROWW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_P1   = 2'd2,
    ST_P2   = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic                hit;
    logic [KBD_COLW-1:0] col;
    logic [KBD_ROWW-1:0] row;
  } kbd_hit_t;

  // rc is the BBC internal key number: row in bits 6:4, column in bits 3:0
  function automatic kbd_hit_t kbd_rc(input logic hit, input logic [6:0] rc);
    kbd_hit_t h;
    h.hit = hit;
    h.col = KBD_COLW'(rc[3:0]);
    h.row = KBD_ROWW'(rc[6:4]);
    return h;
  endfunction

  function automatic kbd_hit_t set1_base_xlate(input logic [6:0] code);
    logic       hit;
    logic [6:0] rc;
    hit = 1'b1;
    rc  = 7'h00;
    case (code)
      7'h01: rc = 7'h70;  7'h02: rc = 7'h30;  7'h03: rc = 7'h31;  7'h04: rc = 7'h11;
      7'h05: rc = 7'h12;  7'h06: rc = 7'h13;  7'h07: rc = 7'h34;  7'h08: rc = 7'h24;
      7'h09: rc = 7'h15;  7'h0A: rc = 7'h26;  7'h0B: rc = 7'h27;  7'h0C: rc = 7'h17;
      7'h0D: rc = 7'h18;  7'h0E: rc = 7'h59;  7'h0F: rc = 7'h60;  7'h10: rc = 7'h10;
      7'h11: rc = 7'h21;  7'h12: rc = 7'h22;  7'h13: rc = 7'h33;  7'h14: rc = 7'h23;
      7'h15: rc = 7'h44;  7'h16: rc = 7'h35;  7'h17: rc = 7'h25;  7'h18: rc = 7'h36;
      7'h19: rc = 7'h37;  7'h1A: rc = 7'h38;  7'h1B: rc = 7'h58;  7'h1C: rc = 7'h49;
      7'h1D: rc = 7'h01;  7'h1E: rc = 7'h41;  7'h1F: rc = 7'h51;  7'h20: rc = 7'h32;
      7'h21: rc = 7'h43;  7'h22: rc = 7'h53;  7'h23: rc = 7'h54;  7'h24: rc = 7'h45;
      7'h25: rc = 7'h46;  7'h26: rc = 7'h56;  7'h27: rc = 7'h57;  7'h28: rc = 7'h48;
      7'h29: rc = 7'h28;  7'h2B: rc = 7'h78;  7'h2C: rc = 7'h61;  7'h2D: rc = 7'h42;
      7'h2E: rc = 7'h52;  7'h2F: rc = 7'h63;  7'h30: rc = 7'h64;  7'h31: rc = 7'h55;
      7'h32: rc = 7'h65;  7'h33: rc = 7'h66;  7'h34: rc = 7'h67;  7'h35: rc = 7'h68;
      7'h39: rc = 7'h62;  7'h3A: rc = 7'h40;  7'h3B: rc = 7'h71;  7'h3C: rc = 7'h72;
      7'h3D: rc = 7'h73;  7'h3E: rc = 7'h14;  7'h3F: rc = 7'h74;  7'h40: rc = 7'h75;
      7'h41: rc = 7'h16;  7'h42: rc = 7'h76;  7'h43: rc = 7'h77;  7'h44: rc = 7'h20;
`ifndef KBD_EXTENDED_KEYS_EN
      // Keypad doubles as cursor/COPY keys when the E0 prefix is not decoded
      7'h47: rc = 7'h47;  7'h48: rc = 7'h39;  7'h4B: rc = 7'h19;  7'h4D: rc = 7'h79;
      7'h4F: rc = 7'h48;  7'h50: rc = 7'h29;  7'h51: rc = 7'h69;
`endif
      default: hit = 1'b0;
    endcase
    return kbd_rc(hit, rc);
  endfunction

  // Cursor keys and COPY sit in BBC column 9
  function automatic kbd_hit_t set1_ext_xlate(input logic [6:0] code);
    logic       hit;
    logic [6:0] rc;
    hit = 1'b1;
    rc  = 7'h00;
    case (code)
      7'h1D: rc = 7'h01;  7'h47: rc = 7'h47;  7'h48: rc = 7'h39;  7'h4B: rc = 7'h19;
      7'h4D: rc = 7'h79;  7'h4F: rc = 7'h48;  7'h50: rc = 7'h29;  7'h51: rc = 7'h69;
      default: hit = 1'b0;
    endcase
    return kbd_rc(hit, rc);
  endfunction

endpackage

// File: rtl/kbd_set1_decoder.sv
// kbd_set1_decoder: set-1 prefix FSM; turns scancode bytes into matrix set/clear/flush strobes.
// state   | meaning
// IDLE    | plain byte: translate, flush on 00/FF, open a prefix on E0/E1
// EXT     | E0 seen, next byte uses the extended table (KBD_EXTENDED_KEYS_EN only)
// P1, P2  | E1 seen, swallowing the two trailing Pause bytes
module kbd_set1_decoder
  import kbd_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic [7:0]          code_i,
  output logic                set_o,
  output logic                clr_o,
  output logic                flush_o,
  output logic [KBD_COLW-1:0] col_o,
  output logic [KBD_ROWW-1:0] row_o,
  output logic                lshift_we_o,
  output logic                rshift_we_o,
  output logic                brk_we_o,
  output logic                flag_val_o
);

  kbd_state_e state_q, state_d;
  kbd_hit_t   xl;
  logic [6:0] code7;
  logic       make;

  assign code7 = code_i[6:0];
  assign make  = ~code_i[7];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    set_o       = 1'b0;
    clr_o       = 1'b0;
    flush_o     = 1'b0;
    lshift_we_o = 1'b0;
    rshift_we_o = 1'b0;
    brk_we_o    = 1'b0;
    flag_val_o  = make;
    xl          = (state_q == ST_EXT) ? set1_ext_xlate(code7) : set1_base_xlate(code7);
    col_o       = xl.col;
    row_o       = xl.row;
    if (valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (code_i == 8'hE0) begin
`ifdef KBD_EXTENDED_KEYS_EN
            state_d = ST_EXT;
`endif
          end else if (code_i == 8'hE1) begin
            state_d = ST_P1;
          end else if (code_i == 8'h00 || code_i == 8'hFF) begin
            flush_o = 1'b1;
          end else if (code7 == 7'h2A) begin
            lshift_we_o = 1'b1;
          end else if (code7 == 7'h36) begin
            rshift_we_o = 1'b1;
          end else if (code7 == 7'h58) begin
            brk_we_o = 1'b1;
          end else begin
            set_o = xl.hit & make;
            clr_o = xl.hit & ~make;
          end
        end
        ST_EXT: begin
          set_o   = xl.hit & make;
          clr_o   = xl.hit & ~make;
          state_d = ST_IDLE;
        end
        ST_P1:   state_d = ST_P2;
        ST_P2:   state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/kbd_matrix.sv
// kbd_matrix: BBC keyboard matrix fed by PS/2 set-1 make/break codes, with VIA-facing match lines.
// Build option: KBD_EXTENDED_KEYS_EN enables the E0-prefixed arrow/COPY table.
module kbd_matrix
  import kbd_pkg::*;
#(
  parameter int NCOLS = KBD_NCOLS,
  parameter int NROWS = KBD_NROWS,
  parameter int COLW  = KBD_COLW,
  parameter int ROWW  = KBD_ROWW
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic            scan_valid,
  input  logic [7:0]      scan_code,
  input  logic            scan_en,
  input  logic            autoscan,
  input  logic [COLW-1:0] column,
  input  logic [ROWW-1:0] row,
  output logic            column_match,
  output logic            row_match,
  output logic            key_irq,
  output logic            break_key
);

  logic                      dec_set, dec_clr, dec_flush;
  logic [KBD_COLW-1:0]       dec_col;
  logic [KBD_ROWW-1:0]       dec_row;
  logic                      dec_lsh_we, dec_rsh_we, dec_brk_we, dec_val;

  logic [NCOLS-1:0][NROWS-1:0] key_q, key_d;
  logic                        lshift_q, lshift_d, rshift_q, rshift_d, brk_q, brk_d;
  logic [COLW-1:0]             cnt_q, cnt_d;
  logic [COLW-1:0]             sel;
  logic [NROWS-1:0]            col_vec;
  logic                        row_hit;
  logic                        cmatch_q, rmatch_q, irq_q, brk_out_q;

  kbd_set1_decoder u_dec (
    .clk_i       (CLK),
    .rst_ni      (nRESET),
    .valid_i     (scan_valid),
    .code_i      (scan_code),
    .set_o       (dec_set),
    .clr_o       (dec_clr),
    .flush_o     (dec_flush),
    .col_o       (dec_col),
    .row_o       (dec_row),
    .lshift_we_o (dec_lsh_we),
    .rshift_we_o (dec_rsh_we),
    .brk_we_o    (dec_brk_we),
    .flag_val_o  (dec_val)
  );

  always_comb begin
    key_d    = key_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    brk_d    = brk_q;
    if (dec_flush) begin
      key_d    = '0;
      lshift_d = 1'b0;
      rshift_d = 1'b0;
      brk_d    = 1'b0;
    end else begin
      for (int c = 0; c < NCOLS; c++) begin
        for (int r = 0; r < NROWS; r++) begin
          if (dec_col == KBD_COLW'(c) && dec_row == KBD_ROWW'(r)) begin
            if (dec_set)      key_d[c][r] = 1'b1;
            else if (dec_clr) key_d[c][r] = 1'b0;
          end
        end
      end
      if (dec_lsh_we) lshift_d = dec_val;
      if (dec_rsh_we) rshift_d = dec_val;
      if (dec_brk_we) brk_d    = dec_val;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (autoscan && scan_en) cnt_d = (cnt_q == COLW'(NCOLS - 1)) ? '0 : cnt_q + 1'b1;
  end

  // Reads use the pre-write matrix; unpopulated column addresses read as empty
  always_comb begin
    sel     = autoscan ? cnt_q : column;
    col_vec = '0;
    for (int c = 0; c < NCOLS; c++) begin
      if (sel == COLW'(c)) col_vec = key_q[c];
    end
    if (sel == '0) col_vec[0] = lshift_q | rshift_q;
    row_hit = 1'b0;
    for (int r = 0; r < NROWS; r++) begin
      if (row == ROWW'(r)) row_hit = col_vec[r];
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      key_q     <= '0;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      brk_q     <= 1'b0;
      cnt_q     <= '0;
      cmatch_q  <= 1'b0;
      rmatch_q  <= 1'b0;
      irq_q     <= 1'b0;
      brk_out_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      brk_q     <= brk_d;
      cnt_q     <= cnt_d;
      cmatch_q  <= |col_vec;
      rmatch_q  <= row_hit;
      irq_q     <= |col_vec[NROWS-1:1];
      brk_out_q <= brk_q;
    end
  end

  assign column_match = cmatch_q;
  assign row_match    = rmatch_q;
  assign key_irq      = irq_q;
  assign break_key    = brk_out_q;

endmodule

// File: tb/tb_kbd_matrix.sv
// tb_kbd_matrix: directed scenarios plus randomized scancode traffic against a table-driven key model.
`timescale 1ns/1ps
module tb_kbd_matrix;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       scan_valid, scan_en, autoscan;
  logic [7:0] scan_code;
  logic [3:0] column;
  logic [2:0] row;
  logic       column_match, row_match, key_irq, break_key;

  int n_checks = 0;
  int n_fail   = 0;

  kbd_matrix dut (
    .CLK          (CLK),
    .nRESET       (nRESET),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .scan_en      (scan_en),
    .autoscan     (autoscan),
    .column       (column),
    .row          (row),
    .column_match (column_match),
    .row_match    (row_match),
    .key_irq      (key_irq),
    .break_key    (break_key)
  );

  always #5 CLK = ~CLK;

  // Reference model: key state per (column,row), shift/break flags, prefix bookkeeping
  bit m_key [10][8];
  bit m_lsh, m_rsh, m_brk, m_ext;
  int m_skip, m_cnt;
  int base_tbl[int];
  int ext_tbl[int];
  int key_codes[$];

  // pairs of (set-1 code, BBC key number 0xRC with row in the high nibble)
  int base_pairs[$] = '{
    'h01,'h70, 'h02,'h30, 'h03,'h31, 'h04,'h11, 'h05,'h12, 'h06,'h13, 'h07,'h34, 'h08,'h24,
    'h09,'h15, 'h0A,'h26, 'h0B,'h27, 'h0C,'h17, 'h0D,'h18, 'h0E,'h59, 'h0F,'h60, 'h10,'h10,
    'h11,'h21, 'h12,'h22, 'h13,'h33, 'h14,'h23, 'h15,'h44, 'h16,'h35, 'h17,'h25, 'h18,'h36,
    'h19,'h37, 'h1A,'h38, 'h1B,'h58, 'h1C,'h49, 'h1D,'h01, 'h1E,'h41, 'h1F,'h51, 'h20,'h32,
    'h21,'h43, 'h22,'h53, 'h23,'h54, 'h24,'h45, 'h25,'h46, 'h26,'h56, 'h27,'h57, 'h28,'h48,
    'h29,'h28, 'h2B,'h78, 'h2C,'h61, 'h2D,'h42, 'h2E,'h52, 'h2F,'h63, 'h30,'h64, 'h31,'h55,
    'h32,'h65, 'h33,'h66, 'h34,'h67, 'h35,'h68, 'h39,'h62, 'h3A,'h40, 'h3B,'h71, 'h3C,'h72,
    'h3D,'h73, 'h3E,'h14, 'h3F,'h74, 'h40,'h75, 'h41,'h16, 'h42,'h76, 'h43,'h77, 'h44,'h20};
  int pad_pairs[$] = '{'h47,'h47, 'h48,'h39, 'h4B,'h19, 'h4D,'h79, 'h4F,'h48, 'h50,'h29, 'h51,'h69};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 10; c++)
      for (int r = 0; r < 8; r++) m_key[c][r] = 1'b0;
    m_lsh = 0; m_rsh = 0; m_brk = 0; m_ext = 0; m_skip = 0; m_cnt = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int code, rc;
    bit make;
    code = int'(b & 8'h7F);
    make = !b[7];
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (m_ext) begin
      m_ext = 0;
      if (ext_tbl.exists(code)) begin
        rc = ext_tbl[code];
        m_key[rc % 16][rc / 16] = make;
      end
      return;
    end
    if (b == 8'hE0) begin
`ifdef KBD_EXTENDED_KEYS_EN
      m_ext = 1;
`endif
    end else if (b == 8'hE1) begin
      m_skip = 2;
    end else if (b == 8'h00 || b == 8'hFF) begin
      for (int c = 0; c < 10; c++)
        for (int r = 0; r < 8; r++) m_key[c][r] = 1'b0;
      m_lsh = 0; m_rsh = 0; m_brk = 0;
    end else if (code == 'h2A) m_lsh = make;
    else if (code == 'h36) m_rsh = make;
    else if (code == 'h58) m_brk = make;
    else if (base_tbl.exists(code)) begin
      rc = base_tbl[code];
      m_key[rc % 16][rc / 16] = make;
    end
  endfunction

  function automatic void model_out(output bit cm, output bit rm, output bit irq);
    int sel;
    bit v;
    sel = autoscan ? m_cnt : int'(column);
    cm = 0; rm = 0; irq = 0;
    if (sel >= 10) return;
    for (int r = 0; r < 8; r++) begin
      v = (sel == 0 && r == 0) ? (m_lsh | m_rsh) : m_key[sel][r];
      cm |= v;
      if (r > 0) irq |= v;
      if (r == int'(row)) rm = v;
    end
  endfunction

  task automatic check_all(input string tag);
    bit cm, rm, irq;
    model_out(cm, rm, irq);
    check_eq({tag, "/column_match"}, column_match, cm);
    check_eq({tag, "/row_match"}, row_match, rm);
    check_eq({tag, "/key_irq"}, key_irq, irq);
    check_eq({tag, "/break_key"}, break_key, m_brk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    tick(1);
    scan_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic pulse();
    scan_en = 1'b1;
    tick(1);
    scan_en = 1'b0;
    if (autoscan) m_cnt = (m_cnt + 1) % 10;
  endtask

  task automatic random_byte(output logic [7:0] b);
    int p;
    p = $urandom_range(0, 99);
    if (p < 60) begin
      b = 8'(key_codes[$urandom_range(0, key_codes.size() - 1)]);
      if ($urandom_range(0, 9) < 4) b[7] = 1'b1;
    end else if (p < 70) begin
      case ($urandom_range(0, 2))
        0: b = 8'h2A;
        1: b = 8'h36;
        default: b = 8'h58;
      endcase
      if ($urandom_range(0, 1) == 1) b[7] = 1'b1;
    end else if (p < 80) b = 8'hE0;
    else if (p < 83) b = 8'hE1;
    else if (p < 85) b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    else b = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [7:0] b;
    int exp_cnt, op, nb;

    for (int i = 0; i < base_pairs.size(); i += 2) begin
      base_tbl[base_pairs[i]] = base_pairs[i+1];
      key_codes.push_back(base_pairs[i]);
    end
    for (int i = 0; i < pad_pairs.size(); i += 2) begin
      ext_tbl[pad_pairs[i]] = pad_pairs[i+1];
`ifndef KBD_EXTENDED_KEYS_EN
      base_tbl[pad_pairs[i]] = pad_pairs[i+1];
`endif
      key_codes.push_back(pad_pairs[i]);
    end
    ext_tbl['h1D] = 'h01;

    nRESET = 1'b0; scan_valid = 1'b0; scan_code = 8'h00; scan_en = 1'b0;
    autoscan = 1'b0; column = 4'd0; row = 3'd0;
    model_reset();
    tick(2);
    check_eq("reset/column_match", column_match, 1'b0);
    check_eq("reset/row_match", row_match, 1'b0);
    check_eq("reset/key_irq", key_irq, 1'b0);
    check_eq("reset/break_key", break_key, 1'b0);
    nRESET = 1'b1;
    tick(1);

    // Q make/break, including one-cycle read latency after the write
    column = 4'd0; row = 3'd1;
    send(8'h10);
    check_eq("q_prewrite/row_match", row_match, 1'b0);
    tick(1);
    check_eq("q_make/row_match", row_match, 1'b1);
    check_eq("q_make/column_match", column_match, 1'b1);
    check_eq("q_make/key_irq", key_irq, 1'b1);
    send(8'h90);
    tick(1);
    check_eq("q_break/row_match", row_match, 1'b0);
    check_eq("q_break/column_match", column_match, 1'b0);
    check_eq("q_break/key_irq", key_irq, 1'b0);

    // Two shift keys share the SHIFT position
    row = 3'd0;
    send(8'h2A); tick(1);
    check_eq("lshift/row_match", row_match, 1'b1);
    send(8'h36); send(8'hAA); tick(1);
    check_eq("rshift_only/row_match", row_match, 1'b1);
    check_eq("rshift_only/key_irq", key_irq, 1'b0);
    send(8'hB6); tick(1);
    check_eq("no_shift/row_match", row_match, 1'b0);
    check_eq("no_shift/key_irq", key_irq, 1'b0);

    // Autoscan over a held A (column 1, row 4)
    send(8'h1E);
    autoscan = 1'b1; row = 3'd4;
    tick(1);
    for (int i = 0; i < 12; i++) begin
      pulse();
      tick(1);
      exp_cnt = (i + 1) % 10;
      check_eq($sformatf("autoscan%0d/key_irq", i), key_irq, (exp_cnt == 1));
      check_all($sformatf("autoscan%0d", i));
    end
    autoscan = 1'b0; column = 4'd15;
    tick(1);
    check_eq("col15/column_match", column_match, 1'b0);
    column = 4'd1; tick(1);
    check_eq("col1/column_match", column_match, 1'b1);
    send(8'h9E);

    // Keypad vs E0-prefixed arrows
    column = 4'd9; row = 3'd3;
    send(8'h48); tick(1);
`ifdef KBD_EXTENDED_KEYS_EN
    check_eq("kp8/row_match", row_match, 1'b0);
`else
    check_eq("kp8/row_match", row_match, 1'b1);
`endif
    send(8'hE0); send(8'h48); tick(1);
    check_eq("e0_up/row_match", row_match, 1'b1);
    send(8'hE0); send(8'hC8); tick(1);
    check_eq("e0_up_brk/row_match", row_match, 1'b0);
    column = 4'd0; row = 3'd0;
    send(8'hE0); send(8'h2A); tick(1);
`ifdef KBD_EXTENDED_KEYS_EN
    check_eq("fake_shift/row_match", row_match, 1'b0);
`else
    check_eq("fake_shift/row_match", row_match, 1'b1);
`endif
    check_all("fake_shift");
    send(8'hAA);

    // Flush, then a swallowed Pause sequence
    send(8'h10); send(8'h1E); send(8'h58); tick(1);
    check_eq("brk_held/break_key", break_key, 1'b1);
    send(8'hFF); tick(1);
    check_eq("flush/break_key", break_key, 1'b0);
    check_eq("flush/col0", column_match, 1'b0);
    column = 4'd1; tick(1);
    check_eq("flush/col1", column_match, 1'b0);
    send(8'hE1); send(8'h1D); send(8'h45); send(8'h10);
    row = 3'd0; tick(1);
    check_eq("pause/ctrl", row_match, 1'b0);
    column = 4'd0; row = 3'd1; tick(1);
    check_eq("pause/q", row_match, 1'b1);
    check_all("pause");

    // Reset in the middle of an E0 prefix
    column = 4'd0; row = 3'd1;
    send(8'hE0);
    nRESET = 1'b0;
    #2;
    check_eq("rst_async/row_match", row_match, 1'b0);
    check_eq("rst_async/column_match", column_match, 1'b0);
    check_eq("rst_async/key_irq", key_irq, 1'b0);
    check_eq("rst_async/break_key", break_key, 1'b0);
    tick(1);
    check_eq("rst_hold/column_match", column_match, 1'b0);
    nRESET = 1'b1;
    model_reset();
    column = 4'd9; row = 3'd3;
    send(8'h48); tick(1);
`ifdef KBD_EXTENDED_KEYS_EN
    check_eq("rst_abort/row_match", row_match, 1'b0);
`else
    check_eq("rst_abort/row_match", row_match, 1'b1);
`endif
    check_all("rst_abort");

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      op = $urandom_range(0, 99);
      if (op < 50) begin
        nb = $urandom_range(1, 4);
        for (int k = 0; k < nb; k++) begin
          random_byte(b);
          send(b);
        end
      end else if (op < 75) begin
        column = 4'($urandom_range(0, 15));
        row    = 3'($urandom_range(0, 7));
      end else if (op < 85) begin
        autoscan = ~autoscan;
      end else begin
        pulse();
      end
      tick(1);
      check_all($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
